systolic_mm_array: RTL and testbench

- Parametrised N x M output-stationary systolic matrix-multiply array: C[NxM] = A[NxK] * B[KxM], with a run-time inner dimension K.
- Successor to the fixed 3x3 MAC test top. Adds internal input skewing, a valid/ready feed handshake with bubble tolerance, signed wide accumulation, and a row-serial result drain with backpressure.
- Sits between the operand buffers and the result writeback.

---
 rtl/systolic_mm_array.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_mm_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_array.sv
// Output-stationary N x M systolic matrix multiply: C = A[NxK] * B[KxM], K chosen per run.
// Latency: first result row N+M cycles after the last accepted feed beat; one row per c_ready beat.
// Backpressure: feed stalls cleanly on a_valid=0 (bubbles); drain holds c_data/c_last while c_ready=0.
//
// Ports: clk/rst (async active-low); start/k_len launch a run from IDLE;
//        a_valid/a_ready/a_data/b_data carry one column of A and one row of B per beat;
//        busy is high outside IDLE; c_valid/c_ready/c_data/c_last drain C one row at a time.
module systolic_mm_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int N          = 3,
    parameter int M          = 3,
    parameter int K_MAX      = 16,
    parameter int KW         = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [N*DATA_WIDTH-1:0]   a_data,
    input  logic [M*DATA_WIDTH-1:0]   b_data,
    output logic                      busy,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic [M*ACC_WIDTH-1:0]    c_data,
    output logic                      c_last
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = $clog2(N + M);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_q;
    logic [FW-1:0]   flush_q;
    logic [RW-1:0]   row_q;
    logic            a_ready_q;
    logic            busy_q;
    logic            c_valid_q;

    // a_ready_q is only ever high in FEED, so this alone qualifies a beat.
    logic beat_acc;
    logic start_ok;
    assign beat_acc = a_valid && a_ready_q;
    assign start_ok = (state_q == IDLE) && start && (k_len != '0) && (k_len <= KW'(K_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            beat_q    <= '0;
            flush_q   <= '0;
            row_q     <= '0;
            a_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        k_q       <= k_len;
                        beat_q    <= '0;
                        a_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= FEED;
                    end
                end
                FEED: begin
                    if (beat_acc) begin
                        beat_q <= beat_q + KW'(1);
                        if (beat_q == k_q - KW'(1)) begin
                            a_ready_q <= 1'b0;
                            flush_q   <= '0;
                            state_q   <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // N+M-1 cycles lets the last beat reach PE(N-1,M-1) and accumulate.
                    if (flush_q == FW'(N + M - 2)) begin
                        row_q     <= '0;
                        c_valid_q <= 1'b1;
                        state_q   <= DRAIN;
                    end else begin
                        flush_q <= flush_q + FW'(1);
                    end
                end
                DRAIN: begin
                    if (c_ready) begin
                        if (row_q == RW'(N - 1)) begin
                            c_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // PE input wires: column 0 / row 0 come from the skew network, the rest from neighbours.
    logic [DW-1:0] a_in  [N][M];
    logic          at_in [N][M];
    logic [DW-1:0] b_in  [N][M];
    logic          bt_in [N][M];
    logic [AW-1:0] acc_w [N][M];

    // Row i of A is delayed i cycles so it meets column j of B on the diagonal wavefront.
    for (genvar gi = 0; gi < N; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign a_in[0][0]  = a_data[0 +: DW];
            assign at_in[0][0] = beat_acc;
        end else begin : g_chain
            logic [DW-1:0] dat_q [gi];
            logic          tag_q [gi];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < gi; s++) begin
                        dat_q[s] <= '0;
                        tag_q[s] <= 1'b0;
                    end
                end else begin
                    dat_q[0] <= a_data[gi*DW +: DW];
                    tag_q[0] <= beat_acc;
                    for (int s = 1; s < gi; s++) begin
                        dat_q[s] <= dat_q[s-1];
                        tag_q[s] <= tag_q[s-1];
                    end
                end
            end
            assign a_in[gi][0]  = dat_q[gi-1];
            assign at_in[gi][0] = tag_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < M; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign b_in[0][0]  = b_data[0 +: DW];
            assign bt_in[0][0] = beat_acc;
        end else begin : g_chain
            logic [DW-1:0] dat_q [gj];
            logic          tag_q [gj];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < gj; s++) begin
                        dat_q[s] <= '0;
                        tag_q[s] <= 1'b0;
                    end
                end else begin
                    dat_q[0] <= b_data[gj*DW +: DW];
                    tag_q[0] <= beat_acc;
                    for (int s = 1; s < gj; s++) begin
                        dat_q[s] <= dat_q[s-1];
                        tag_q[s] <= tag_q[s-1];
                    end
                end
            end
            assign b_in[0][gj]  = dat_q[gj-1];
            assign bt_in[0][gj] = tag_q[gj-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < M; gj++) begin : g_pe
            logic [DW-1:0]          a_q;
            logic [DW-1:0]          b_q;
            logic                   at_q;
            logic                   bt_q;
            logic signed [AW-1:0]   acc_q;
            logic signed [2*DW-1:0] prod;

            assign prod = $signed(a_q) * $signed(b_q);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    at_q  <= 1'b0;
                    bt_q  <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q  <= a_in[gi][gj];
                    at_q <= at_in[gi][gj];
                    b_q  <= b_in[gi][gj];
                    bt_q <= bt_in[gi][gj];
                    if (start_ok) begin
                        acc_q <= '0;
                    end else if (at_q && bt_q) begin
                        // Signed cast sign-extends the product; the sum wraps at AW bits.
                        acc_q <= acc_q + AW'(prod);
                    end
                end
            end

            if (gj < M - 1) begin : g_east
                assign a_in[gi][gj+1]  = a_q;
                assign at_in[gi][gj+1] = at_q;
            end
            if (gi < N - 1) begin : g_south
                assign b_in[gi+1][gj]  = b_q;
                assign bt_in[gi+1][gj] = bt_q;
            end
            assign acc_w[gi][gj] = acc_q;
        end
    end

    always_comb begin
        c_data = '0;
        if (c_valid_q) begin
            for (int j = 0; j < M; j++) begin
                c_data[j*AW +: AW] = acc_w[row_q][j];
            end
        end
    end

    assign c_last  = c_valid_q && (row_q == RW'(N - 1));
    assign a_ready = a_ready_q;
    assign busy    = busy_q;
    assign c_valid = c_valid_q;

endmodule

// File: tb/tb_systolic_mm_array.sv
module tb_systolic_mm_array;

    localparam int DW    = 16;
    localparam int AW    = 40;
    localparam int N     = 3;
    localparam int M     = 3;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [KW-1:0]        k_len = '0;
    logic                 a_valid = 1'b0;
    logic                 a_ready;
    logic [N*DW-1:0]      a_data = '0;
    logic [M*DW-1:0]      b_data = '0;
    logic                 busy;
    logic                 c_valid;
    logic                 c_ready = 1'b0;
    logic [M*AW-1:0]      c_data;
    logic                 c_last;

    systolic_mm_array #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .M(M), .K_MAX(K_MAX), .KW(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
        .busy(busy), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_last(c_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [M*AW-1:0] got, input logic [M*AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: operands per accepted beat, and C computed by plain arithmetic.
    int            a_m [K_MAX][N];
    int            b_m [K_MAX][M];
    logic [AW-1:0] exp_c [N][M];

    function automatic void model(input int k);
        logic signed [AW-1:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                s = '0;
                for (int kk = 0; kk < k; kk++) begin
                    s += AW'(longint'(a_m[kk][i]) * longint'(b_m[kk][j]));
                end
                exp_c[i][j] = s;
            end
        end
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Result monitor: every cycle c_valid is high, the row must equal the model.
    int mon_row = 0;
    bit mon_exp = 1'b0;

    always @(negedge clk) begin
        if (rst && c_valid) begin
            if (!mon_exp || mon_row >= N) begin
                chk("unexpected_c_valid", c_valid, 1'b0);
            end else begin
                logic [M*AW-1:0] expv;
                for (int j = 0; j < M; j++) expv[j*AW +: AW] = exp_c[mon_row][j];
                chk($sformatf("c_data_row%0d", mon_row), c_data, expv);
                chk($sformatf("c_last_row%0d", mon_row), c_last, (mon_row == N - 1));
                if (c_ready) begin
                    mon_row++;
                    if (mon_row == N) mon_exp = 1'b0;
                end
            end
        end
    end

    task automatic drive_junk();
        a_data = (N*DW)'({$urandom, $urandom});
        b_data = (M*DW)'({$urandom, $urandom});
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) a_data[i*DW +: DW] = DW'(a_m[kk][i]);
        for (int j = 0; j < M; j++) b_data[j*DW +: DW] = DW'(b_m[kk][j]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_ready"}, a_ready, 1'b0);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_c_valid"}, c_valid, 1'b0);
        chk({tag, "_c_data"},  c_data,  '0);
        chk({tag, "_c_last"},  c_last,  1'b0);
    endtask

    // One full run. gap<0 picks random bubbles per beat. Row bp_row is refused bp_cyc times.
    task automatic do_op(input int k, input int gap, input int bp_row, input int bp_cyc);
        int g, n, hs, bp, last_cyc;
        mon_row = 0;
        mon_exp = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("a_ready_in_feed", a_ready, 1'b1);
        last_cyc = 0;
        for (int kk = 0; kk < k; kk++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((kk > 0) ? gap : 0);
            repeat (g) begin
                a_valid = 1'b0; drive_junk();
                @(posedge clk); #1;
            end
            a_valid = 1'b1; drive_beat(kk);
            last_cyc = cyc;
            @(posedge clk); #1;
        end
        chk("a_ready_drop", a_ready, 1'b0);
        // Junk beats and a stray start while busy must change nothing.
        drive_junk();
        start = 1'b1; k_len = KW'(2);
        n = 0;
        while (!c_valid && n < 100) begin
            @(posedge clk); #1;
            start = 1'b0; drive_junk();
            n++;
        end
        start = 1'b0;
        chk("first_c_valid_latency", cyc - last_cyc, N + M);
        hs = 0; bp = 0; n = 0;
        while (hs < N && n < 200) begin
            c_ready = !(hs == bp_row && bp < bp_cyc);
            if (!c_ready) bp++;
            if (c_valid && c_ready) hs++;
            drive_junk();
            @(posedge clk); #1;
            n++;
        end
        c_ready = 1'b0;
        a_valid = 1'b0;
        chk("busy_after_last_row", busy, 1'b0);
        chk("c_valid_after_last_row", c_valid, 1'b0);
        chk("rows_drained", mon_row, N);
    endtask

    task automatic load_outer();
        a_m[0][0] = 1; a_m[0][1] = 2; a_m[0][2] = 3;
        b_m[0][0] = 4; b_m[0][1] = 5; b_m[0][2] = 6;
        model(1);
    endtask

    task automatic load_identity();
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < N; i++) a_m[kk][i] = (i == kk) ? 1 : 0;
            for (int j = 0; j < M; j++) b_m[kk][j] = kk * 3 + j + 1;
        end
        model(3);
    endtask

    initial begin
        #1 rst = 1'b0;
        #10;
        chk_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("post_reset");

        // Illegal starts.
        start = 1'b1; k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_k0", busy, 1'b0);
        chk("a_ready_k0", a_ready, 1'b0);
        start = 1'b1; k_len = KW'(K_MAX + 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_k17", busy, 1'b0);

        // Outer product.
        load_outer();
        chk("model_outer_c12", exp_c[1][2], AW'(12));
        do_op(1, 0, -1, 0);

        // Identity, back-to-back then with two-cycle bubbles.
        load_identity();
        chk("model_ident_c20", exp_c[2][0], AW'(7));
        do_op(3, 0, -1, 0);
        do_op(3, 2, -1, 0);

        // Signed operands in PE(0,0).
        for (int kk = 0; kk < 2; kk++) begin
            for (int i = 0; i < N; i++) a_m[kk][i] = rnd16();
            for (int j = 0; j < M; j++) b_m[kk][j] = rnd16();
        end
        a_m[0][0] = -2;     b_m[0][0] = 3;
        a_m[1][0] = -32768; b_m[1][0] = -32768;
        model(2);
        chk("model_signed_c00", exp_c[0][0], AW'(1073741818));
        do_op(2, 0, -1, 0);

        // Backpressure on row 1.
        load_identity();
        do_op(3, 0, 1, 5);

        // Reset mid-FEED after one beat.
        load_outer();
        mon_exp = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        a_valid = 1'b1; drive_beat(0);
        @(posedge clk); #1;
        a_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_zero("mid_feed_reset");
        @(negedge clk); rst = 1'b1;
        chk("model_outer_c21", exp_c[2][1], AW'(15));
        do_op(1, 0, -1, 0);

        // Randomized runs across the full operand range.
        for (int r = 0; r < 10; r++) begin
            int k;
            k = int'($urandom_range(1, K_MAX));
            for (int kk = 0; kk < k; kk++) begin
                for (int i = 0; i < N; i++) a_m[kk][i] = rnd16();
                for (int j = 0; j < M; j++) b_m[kk][j] = rnd16();
            end
            model(k);
            do_op(k, -1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors + 1, checks);
        $fatal(1, "watchdog");
    end

endmodule
